// File: rtl/windowed_reg_file_pkg.sv
// Shared types and the logical->physical register mapping of the windowed RF.
// Pure combinational helpers; no state, no backpressure.
package sparc_rf_pkg;

  localparam int NWINDOWS_DEF = 4;

  typedef enum logic {FILL, RUN} rf_state_e;

  function automatic int phys_count(input int nwin);
    return 8 + 16 * nwin;
  endfunction

  // r0..r7 sit at their own index; windowed regs rotate through a 16*nwin ring,
  // so the ins of window w land on the outs of window w+1.
  function automatic int phys_idx(input int cwp, input int r, input int nwin);
    if (r < 8) return r;
    return 8 + ((cwp * 16 + r - 8) % (16 * nwin));
  endfunction

endpackage

// File: rtl/windowed_reg_file_map.sv
// Logical register number + CWP -> physical entry index.
// Combinational, zero latency; no flow control.
module rf_window_map
  import sparc_rf_pkg::*;
#(
  parameter int NWINDOWS = NWINDOWS_DEF,
  parameter int CWPW     = 5,
  parameter int PW       = 7
) (
  input  logic [CWPW-1:0] cwp,
  input  logic [4:0]      r,
  output logic [PW-1:0]   phys
);

  assign phys = PW'(phys_idx(int'(cwp), int'(r), NWINDOWS));

endmodule

// File: rtl/windowed_reg_file.sv
// SPARC windowed register file: CWP/trap control, post-reset zero fill, 2R/1W.
// Reads combinational; RF_BYPASS_EN forwards same-cycle write data to read ports.
module windowed_reg_file
  import sparc_rf_pkg::*;
#(
  parameter int NWINDOWS = NWINDOWS_DEF,
  parameter int WIDTH    = 32,
  parameter int CWPW     = 5
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [4:0]       RC,
  input  logic [WIDTH-1:0] Rin,
  input  logic             RFE,
  input  logic             SAVE,
  input  logic             RESTORE,
  input  logic [31:0]      WIM,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  output logic [CWPW-1:0]  CWP,
  output logic             WOVF,
  output logic             WUNF,
  output logic             Busy
);

  localparam int PHYS = phys_count(NWINDOWS);
  localparam int PW   = $clog2(PHYS);

  rf_state_e        state;
  logic [PW-1:0]    fill_idx;
  logic [CWPW-1:0]  cwp_q;
  logic [CWPW-1:0]  save_w;
  logic [CWPW-1:0]  restore_w;
  logic [PW-1:0]    pa, pb, pc;
  logic             do_save, do_restore;
  logic [WIDTH-1:0] mem [PHYS];

  rf_window_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_map_a (.cwp(cwp_q), .r(RA), .phys(pa));
  rf_window_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_map_b (.cwp(cwp_q), .r(RB), .phys(pb));
  rf_window_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_map_c (.cwp(cwp_q), .r(RC), .phys(pc));

  assign save_w     = (cwp_q == '0) ? CWPW'(NWINDOWS - 1) : cwp_q - CWPW'(1);
  assign restore_w  = (cwp_q == CWPW'(NWINDOWS - 1)) ? '0 : cwp_q + CWPW'(1);
  assign do_save    = SAVE && !RESTORE;
  assign do_restore = RESTORE && !SAVE;
  assign CWP        = cwp_q;

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state    <= FILL;
      fill_idx <= '0;
      cwp_q    <= '0;
      WOVF     <= 1'b0;
      WUNF     <= 1'b0;
      Busy     <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          fill_idx <= fill_idx + PW'(1);
          if (fill_idx == PW'(PHYS - 1)) begin
            state <= RUN;
            Busy  <= 1'b0;
          end
        end
        RUN: begin
          // A trapping request leaves CWP where it was.
          WOVF <= do_save && WIM[save_w];
          WUNF <= do_restore && WIM[restore_w];
          if (do_save && !WIM[save_w])
            cwp_q <= save_w;
          else if (do_restore && !WIM[restore_w])
            cwp_q <= restore_w;
        end
        default: state <= FILL;
      endcase
    end
  end

  // Storage has no reset of its own; the FILL sweep clears it. Entry 0 is never
  // written with data, so r0 keeps reading zero.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      if (state == FILL)
        mem[fill_idx] <= '0;
      else if (RFE && RC != 5'd0)
        mem[pc] <= Rin;
    end
  end

  always_comb begin
    Aout = '0;
    Bout = '0;
    if (state == RUN) begin
      Aout = mem[pa];
      Bout = mem[pb];
`ifdef RF_BYPASS_EN
      if (RFE && RC != 5'd0) begin
        if (pa == pc) Aout = Rin;
        if (pb == pc) Bout = Rin;
      end
`endif
    end
  end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Scoreboard bench for windowed_reg_file: window-level model (globals/outs/locals
// arrays) predicts every cycle's outputs; a negedge monitor compares them.
module tb_windowed_reg_file;

  localparam int NW   = 4;
  localparam int PHYS = 8 + 16 * NW;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic [4:0]  RA = '0, RB = '0, RC = '0;
  logic [31:0] Rin = '0;
  logic        RFE = 1'b0, SAVE = 1'b0, RESTORE = 1'b0;
  logic [31:0] WIM = '0;
  logic [31:0] Aout, Bout;
  logic [4:0]  CWP;
  logic        WOVF, WUNF, Busy;

  windowed_reg_file #(.NWINDOWS(NW), .WIDTH(32), .CWPW(5)) dut (
    .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .RC(RC), .Rin(Rin), .RFE(RFE),
    .SAVE(SAVE), .RESTORE(RESTORE), .WIM(WIM), .Aout(Aout), .Bout(Bout),
    .CWP(CWP), .WOVF(WOVF), .WUNF(WUNF), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  cwp;
    logic        wovf;
    logic        wunf;
    logic        busy;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  bit   chk = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: architectural view of the windows.
  logic [31:0] glob [8];
  logic [31:0] outs [NW][8];
  logic [31:0] locs [NW][8];
  int          m_cwp = 0;
  int          m_fill = 0;
  bit          m_wovf = 0, m_wunf = 0, m_valid = 0;

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
    if (r < 8)  return glob[r];
    if (r < 16) return outs[m_cwp][r-8];
    if (r < 24) return locs[m_cwp][r-16];
    return outs[(m_cwp + 1) % NW][r-24];
  endfunction

  task automatic m_write(input int r, input logic [31:0] d);
    if (r == 0) return;
    if (r < 8)       glob[r] = d;
    else if (r < 16) outs[m_cwp][r-8] = d;
    else if (r < 24) locs[m_cwp][r-16] = d;
    else             outs[(m_cwp + 1) % NW][r-24] = d;
  endtask

  task automatic m_clear();
    foreach (glob[i]) glob[i] = '0;
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < 8; i++) begin
        outs[w][i] = '0;
        locs[w][i] = '0;
      end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  always @(negedge Clk) begin
    if (chk) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        mon_e = expq.pop_front();
        check("Aout", Aout, mon_e.a);
        check("Bout", Bout, mon_e.b);
        check("CWP",  32'(CWP),  32'(mon_e.cwp));
        check("WOVF", 32'(WOVF), 32'(mon_e.wovf));
        check("WUNF", 32'(WUNF), 32'(mon_e.wunf));
        check("Busy", 32'(Busy), 32'(mon_e.busy));
      end
    end
  end

  // One clock of stimulus: predict this cycle's outputs, then advance the model at the edge.
  task automatic cyc(input logic clr_i, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [4:0] rc, input logic [31:0] rin, input logic rfe,
                     input logic sv, input logic rs);
    exp_t e;
    bit   wr_ok;
    int   nw;
    Clr = clr_i; RA = ra; RB = rb; RC = rc; Rin = rin; RFE = rfe; SAVE = sv; RESTORE = rs;
    wr_ok = (m_fill == 0) && rfe && (rc != 5'd0);
    if (m_valid) begin
`ifdef RF_BYPASS_EN
      if (wr_ok) m_write(int'(rc), rin);
`endif
      e.a    = (m_fill > 0) ? 32'h0 : m_read(int'(ra));
      e.b    = (m_fill > 0) ? 32'h0 : m_read(int'(rb));
      e.cwp  = 5'(m_cwp);
      e.wovf = m_wovf;
      e.wunf = m_wunf;
      e.busy = (m_fill > 0);
`ifndef RF_BYPASS_EN
      if (wr_ok) m_write(int'(rc), rin);
`endif
      expq.push_back(e);
      chk = 1;
    end else begin
      chk = 0;
    end
    @(posedge Clk);
    if (!clr_i) begin
      m_cwp = 0; m_wovf = 0; m_wunf = 0; m_fill = PHYS; m_valid = 1;
      m_clear();
    end else if (m_fill > 0) begin
      m_fill--;
    end else begin
      m_wovf = 0;
      m_wunf = 0;
      if (sv && !rs) begin
        nw = (m_cwp + NW - 1) % NW;
        if (WIM[nw]) m_wovf = 1; else m_cwp = nw;
      end else if (rs && !sv) begin
        nw = (m_cwp + 1) % NW;
        if (WIM[nw]) m_wunf = 1; else m_cwp = nw;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_fill();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(PHYS);
  endtask

  initial begin
    @(posedge Clk);
    #1;
    // Reset, full fill, then every logical register reads zero.
    reset_fill();
    for (int r = 0; r < 16; r++)
      cyc(1'b1, 5'(r), 5'(r + 16), 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // r8 written in window 0 becomes r24 after SAVE wraps CWP to 3.
    cyc(1'b1, 5'd0, 5'd0, 5'd8, 32'hAAAA0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd24, 5'd8, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Overflow trap on invalid window 3, then a clean RESTORE.
    reset_fill();
    WIM = 32'h8;
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    WIM = 32'h0;

    // Globals survive window changes; r0 stays zero.
    reset_fill();
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd5, 5'd0, 5'd0, 32'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Read-during-write on r16.
    cyc(1'b1, 5'd0, 5'd0, 5'd16, 32'h1111, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd16, 5'd16, 5'd16, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd16, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset mid-fill restarts the sweep; SAVE+RESTORE together is a no-op.
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(30);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(PHYS + 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Random traffic with occasional window-invalid masks.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0)
        WIM = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, NW - 1)) : 32'h0;
      cyc(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
    end
    chk = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
